// File: rtl/axis_slav_demux.sv
// axis_slav_demux: fans one AXI-Stream input out to pNUM_UP user-project
// channels. The destination is locked for the whole packet. Beats aimed at a
// non-existent project are accepted, discarded and counted. A registered
// 2-entry skid buffer lets a registered s_tready still sustain one beat per
// cycle.
module axis_slav_demux #(
    parameter int pNUM_UP                      = 4,
    parameter int pDATA_WIDTH                  = 32,
    parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
    parameter int pSEL_WIDTH                   = 5
) (
    input  logic                                    axis_clk,
    input  logic                                    axis_rst_n,
    input  logic [pSEL_WIDTH-1:0]                   user_prj_sel,
    input  logic                                    s_tvalid,
    input  logic [pDATA_WIDTH-1:0]                  s_tdata,
    input  logic [1:0]                              s_tuser,
    input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] s_tupsb,
    input  logic [pDATA_WIDTH/8-1:0]                s_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]                s_tkeep,
    input  logic                                    s_tlast,
    output logic                                    s_tready,
    output logic [pNUM_UP-1:0]                      ss_tvalid,
    input  logic [pNUM_UP-1:0]                      ss_tready,
    output logic [pDATA_WIDTH-1:0]                  ss_tdata,
    output logic [1:0]                              ss_tuser,
    output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] ss_tupsb,
    output logic [pDATA_WIDTH/8-1:0]                ss_tstrb,
    output logic [pDATA_WIDTH/8-1:0]                ss_tkeep,
    output logic                                    ss_tlast,
    output logic [15:0]                             drop_cnt
);

    localparam int STRB_W = pDATA_WIDTH / 8;
    // Project count widened by one bit so 32 projects with a 5-bit select still fits.
    localparam logic [pSEL_WIDTH:0] NUM_UP_EXT = (pSEL_WIDTH + 1)'(pNUM_UP);

    typedef struct packed {
        logic [pDATA_WIDTH-1:0]                  data;
        logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] upsb;
        logic [STRB_W-1:0]                       strb;
        logic [STRB_W-1:0]                       keep;
        logic                                    last;
        logic [pSEL_WIDTH-1:0]                   dest;
    } entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    pkt_state_e            state_q, state_d;
    logic [pSEL_WIDTH-1:0] lock_sel_q, lock_sel_d;
    entry_t                buf_q [2];
    entry_t                buf_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  s_tready_q, s_tready_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  accept;
    logic                  dest_valid;
    logic                  push;
    logic                  pop;
    logic [pSEL_WIDTH-1:0] dest;
    entry_t                head;
    logic [pNUM_UP-1:0]    valid_vec;

    // s_tuser is deliberately dropped; reduce it so it is not left dangling.
    logic unused_tuser;
    assign unused_tuser = ^s_tuser;

    assign accept     = s_tvalid & s_tready_q;
    assign dest_valid = {1'b0, dest} < NUM_UP_EXT;
    assign push       = accept & dest_valid;
    assign head       = buf_q[rd_ptr_q];

    // Packet lock: the first beat picks the destination, later beats reuse it until tlast.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        dest       = lock_sel_q;
        case (state_q)
            ST_IDLE: begin
                dest = user_prj_sel;
                if (accept) begin
                    lock_sel_d = user_prj_sel;
                    if (!s_tlast) begin
                        state_d = ST_IN_PKT;
                    end
                end
            end
            ST_IN_PKT: begin
                dest = lock_sel_q;
                if (accept && s_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One-hot valid toward the channel named by the head entry.
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < pNUM_UP; i++) begin
            valid_vec[i] = (count_q != 2'd0) && (head.dest == pSEL_WIDTH'(i));
        end
    end

    assign pop = |(valid_vec & ss_tready);

    // Skid buffer bookkeeping; s_tready looks at the occupancy after this cycle.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            buf_d[wr_ptr_q].data = s_tdata;
            buf_d[wr_ptr_q].upsb = s_tupsb;
            buf_d[wr_ptr_q].strb = s_tstrb;
            buf_d[wr_ptr_q].keep = s_tkeep;
            buf_d[wr_ptr_q].last = s_tlast;
            buf_d[wr_ptr_q].dest = dest;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        s_tready_d = (count_d < 2'd2);
    end

    // Saturating count of beats discarded for a non-existent project.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !dest_valid && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // State registers; reset flushes the buffer and forgets any partial packet.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            s_tready_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            s_tready_q <= s_tready_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_tready  = s_tready_q;
    assign ss_tvalid = valid_vec;
    assign ss_tdata  = head.data;
    assign ss_tuser  = 2'b00;
    assign ss_tupsb  = head.upsb;
    assign ss_tstrb  = head.strb;
    assign ss_tkeep  = head.keep;
    assign ss_tlast  = head.last;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_axis_slav_demux.sv
// Testbench for axis_slav_demux: a queue-based reference model of the demux
// is checked against the DUT on every falling edge, with directed scenarios,
// a randomized run and a few hand-computed literal checks.
module tb_axis_slav_demux;

   localparam int NUM_UP = 4;

   typedef struct {
      int          dest;
      logic [31:0] data;
      logic [4:0]  upsb;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic [4:0]  userPrjSel = '0;
   logic        sTvalid = 1'b0;
   logic [31:0] sTdata = '0;
   logic [1:0]  sTuser = '0;
   logic [4:0]  sTupsb = '0;
   logic [3:0]  sTstrb = '0;
   logic [3:0]  sTkeep = '0;
   logic        sTlast = 1'b0;
   logic        sTready;
   logic [3:0]  ssTvalid;
   logic [3:0]  ssTready = 4'b1111;
   logic [31:0] ssTdata;
   logic [1:0]  ssTuser;
   logic [4:0]  ssTupsb;
   logic [3:0]  ssTstrb;
   logic [3:0]  ssTkeep;
   logic        ssTlast;
   logic [15:0] dropCnt;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the buffer holds, the packet lock and the counters.
   beat_t       expQ[$];
   logic        expReady = 1'b0;
   logic [15:0] expDrop = '0;
   logic        mInPkt = 1'b0;
   int          mLock = 0;

   // Short trace of outputs used by the literal checks of the first scenario.
   logic        traceOn = 1'b0;
   logic [3:0]  traceV[$];
   logic [31:0] traceD[$];
   logic        traceL[$];

   logic        randReady = 1'b0;

   axis_slav_demux #(
      .pNUM_UP(NUM_UP),
      .pDATA_WIDTH(32),
      .pUSER_PROJECT_SIDEBAND_WIDTH(5),
      .pSEL_WIDTH(5)
   ) dut (
      .axis_clk(clk),
      .axis_rst_n(rstN),
      .user_prj_sel(userPrjSel),
      .s_tvalid(sTvalid),
      .s_tdata(sTdata),
      .s_tuser(sTuser),
      .s_tupsb(sTupsb),
      .s_tstrb(sTstrb),
      .s_tkeep(sTkeep),
      .s_tlast(sTlast),
      .s_tready(sTready),
      .ss_tvalid(ssTvalid),
      .ss_tready(ssTready),
      .ss_tdata(ssTdata),
      .ss_tuser(ssTuser),
      .ss_tupsb(ssTupsb),
      .ss_tstrb(ssTstrb),
      .ss_tkeep(ssTkeep),
      .ss_tlast(ssTlast),
      .drop_cnt(dropCnt)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case something stalls forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete (actual running, required finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one value and report a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The model: a beat entering or leaving the buffer is decided from the
   // handshake rules alone, the buffer itself is just an ordered queue.
   always @(posedge clk or negedge rstN) begin
      int    dest;
      beat_t b;
      if (!rstN) begin
         expQ.delete();
         mInPkt   = 1'b0;
         mLock    = 0;
         expDrop  = '0;
         expReady = 1'b0;
      end else begin
         if (expQ.size() > 0 && ssTready[expQ[0].dest]) begin
            void'(expQ.pop_front());
         end
         if (sTvalid && expReady) begin
            dest = mInPkt ? mLock : int'(userPrjSel);
            if (!mInPkt) mLock = int'(userPrjSel);
            if (dest < NUM_UP) begin
               b.dest = dest;
               b.data = sTdata;
               b.upsb = sTupsb;
               b.strb = sTstrb;
               b.keep = sTkeep;
               b.last = sTlast;
               expQ.push_back(b);
            end else if (expDrop != 16'hFFFF) begin
               expDrop = expDrop + 16'd1;
            end
            mInPkt = !sTlast;
         end
         expReady = (expQ.size() < 2);
      end
   end

   // Every falling edge, the DUT outputs must match what the model holds.
   always @(negedge clk) begin
      logic [3:0] expValid;
      expValid = (expQ.size() > 0) ? 4'(1 << expQ[0].dest) : 4'b0000;
      checkOutput("s_tready", 64'(sTready), 64'(expReady));
      checkOutput("ss_tvalid", 64'(ssTvalid), 64'(expValid));
      checkOutput("drop_cnt", 64'(dropCnt), 64'(expDrop));
      checkOutput("ss_tuser", 64'(ssTuser), 64'(2'b00));
      if (expQ.size() > 0) begin
         checkOutput("ss_tdata", 64'(ssTdata), 64'(expQ[0].data));
         checkOutput("ss_tupsb", 64'(ssTupsb), 64'(expQ[0].upsb));
         checkOutput("ss_tstrb", 64'(ssTstrb), 64'(expQ[0].strb));
         checkOutput("ss_tkeep", 64'(ssTkeep), 64'(expQ[0].keep));
         checkOutput("ss_tlast", 64'(ssTlast), 64'(expQ[0].last));
      end
      if (traceOn) begin
         traceV.push_back(ssTvalid);
         traceD.push_back(ssTdata);
         traceL.push_back(ssTlast);
      end
   end

   // Offer one beat and hold it until the handshake completes.
   task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] data, input logic last);
      logic rdy;
      int   waitCnt;
      waitCnt = 0;
      @(negedge clk);
      userPrjSel = sel;
      sTvalid    = 1'b1;
      sTdata     = data;
      sTlast     = last;
      sTupsb     = 5'($urandom);
      sTstrb     = 4'($urandom);
      sTkeep     = 4'($urandom);
      sTuser     = 2'($urandom);
      forever begin
         rdy = expReady;
         @(posedge clk);
         if (rdy) break;
         waitCnt++;
         if (waitCnt > 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: actual=no handshake required=handshake for data 0x%0h", data);
            break;
         end
         @(negedge clk);
      end
      #1;
      sTvalid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed scenarios, random traffic and a mid-packet reset.
   initial begin
      int first;
      int beats;
      int len;
      logic [4:0] sel;

      $display("[TB] starting");
      #1 rstN = 1'b0;
      idleCycles(3);
      checkOutput("reset_s_tready", 64'(sTready), 64'd0);
      checkOutput("reset_ss_tvalid", 64'(ssTvalid), 64'd0);
      rstN = 1'b1;
      idleCycles(1);
      checkOutput("release_s_tready", 64'(sTready), 64'd1);

      // Scenario 1: 4-beat packet on project 2, back to back.
      $display("[TB] scenario 1: basic packet to project 2");
      traceV.delete(); traceD.delete(); traceL.delete();
      traceOn = 1'b1;
      applyStimulus(5'd2, 32'h11, 1'b0);
      applyStimulus(5'd2, 32'h12, 1'b0);
      applyStimulus(5'd2, 32'h13, 1'b0);
      applyStimulus(5'd2, 32'h14, 1'b1);
      idleCycles(3);
      traceOn = 1'b0;
      first = -1;
      for (int i = 0; i < traceV.size(); i++) begin
         if (first < 0 && traceV[i] != 4'b0000) first = i;
      end
      if (first < 0 || first + 4 >= traceV.size()) begin
         checkOutput("t1_presented", 64'(first), 64'(traceV.size()));
      end else begin
         for (int k = 0; k < 4; k++) begin
            checkOutput("t1_valid", 64'(traceV[first + k]), 64'(4'b0100));
            checkOutput("t1_data", 64'(traceD[first + k]), 64'(32'h11 + 32'(k)));
            checkOutput("t1_last", 64'(traceL[first + k]), 64'(k == 3));
         end
         checkOutput("t1_after", 64'(traceV[first + 4]), 64'd0);
      end

      // Scenario 2: select changes mid-packet; the packet stays on project 1.
      $display("[TB] scenario 2: packet lock");
      applyStimulus(5'd1, 32'h21, 1'b0);
      applyStimulus(5'd3, 32'h22, 1'b0);
      applyStimulus(5'd3, 32'h23, 1'b1);
      applyStimulus(5'd3, 32'h31, 1'b0);
      applyStimulus(5'd3, 32'h32, 1'b1);
      idleCycles(4);

      // Scenario 3: a packet for project 7 is swallowed and counted.
      $display("[TB] scenario 3: invalid destination");
      for (int k = 0; k < 5; k++) applyStimulus(5'd7, 32'h50 + 32'(k), k == 4);
      idleCycles(2);
      checkOutput("t3_drop_cnt", 64'(dropCnt), 64'd5);
      checkOutput("t3_no_valid", 64'(ssTvalid), 64'd0);
      applyStimulus(5'd0, 32'h61, 1'b0);
      applyStimulus(5'd0, 32'h62, 1'b1);
      idleCycles(4);

      // Scenario 4: project 0 stalls for six cycles while three beats arrive.
      $display("[TB] scenario 4: stall on project 0");
      ssTready = 4'b1110;
      fork
         begin
            applyStimulus(5'd0, 32'h41, 1'b0);
            applyStimulus(5'd0, 32'h42, 1'b0);
            applyStimulus(5'd0, 32'h43, 1'b1);
         end
         begin
            repeat (6) @(negedge clk);
            #1;
            checkOutput("t4_s_tready", 64'(sTready), 64'd0);
            checkOutput("t4_head_valid", 64'(ssTvalid), 64'(4'b0001));
            checkOutput("t4_head_data", 64'(ssTdata), 64'(32'h41));
            ssTready = 4'b1111;
         end
      join
      idleCycles(4);

      // Scenario 5: random traffic with random per-project readiness.
      $display("[TB] scenario 5: random traffic");
      randReady = 1'b1;
      fork
         begin
            while (randReady) begin
               @(negedge clk);
               ssTready = 4'($urandom);
            end
         end
      join_none
      beats = 0;
      while (beats < 1000) begin
         sel = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idleCycles(1);
            applyStimulus((b == 0) ? sel : 5'($urandom_range(0, 31)), $urandom, b == len - 1);
            beats++;
         end
      end
      randReady = 1'b0;
      idleCycles(2);
      ssTready = 4'b1111;
      idleCycles(5);

      // Scenario 6: reset with two beats of an open packet sitting in the buffer.
      $display("[TB] scenario 6: reset mid-packet");
      ssTready = 4'b0000;
      applyStimulus(5'd1, 32'h71, 1'b0);
      applyStimulus(5'd1, 32'h72, 1'b0);
      rstN = 1'b0;
      #1;
      checkOutput("t6_ss_tvalid", 64'(ssTvalid), 64'd0);
      checkOutput("t6_drop_cnt", 64'(dropCnt), 64'd0);
      checkOutput("t6_s_tready", 64'(sTready), 64'd0);
      idleCycles(2);
      rstN = 1'b1;
      ssTready = 4'b1111;
      applyStimulus(5'd3, 32'h81, 1'b0);
      applyStimulus(5'd3, 32'h82, 1'b1);
      idleCycles(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
